nios2_jtag_ocimem_ctrl: RTL and testbench
=========================================

# nios2_jtag_ocimem_ctrl

System-clock-side consumer of the Nios II JTAG debug module's decoded commands (`jdo`, `take_action_ocimem_*`). It owns a single-port on-chip debug RAM and services host reads/writes that arrive over JTAG, with address auto-increment. It returns read data and status through `MonDReg`, `monitor_ready` and `monitor_error` to the JTAG capture path. A CPU-side Avalon-MM slave shares the RAM; the JTAG side has priority.

## Interface
- `ADDR_W`, 8, word-address width; RAM depth is 2^ADDR_W words of 32 bits.
- `clk`  in  1  system clock; all logic is on this single clock.
- `reset`  in  1  synchronous, active-high reset.
- `jdo`  in  38  command payload from the debug module, sampled only in a `take_*` cycle.
- `take_action_ocimem_a`  in  1  load address; `jdo[ADDR_W-1:0]` = word address, `jdo[35]` = read-after-load, `jdo[34]` = clear error.
- `take_action_ocimem_b`  in  1  write `jdo[31:0]` to `RAM[MonAReg]`, then increment.
- `take_no_action_ocimem_a`  in  1  read `RAM[MonAReg]`, then increment.
- `avs_address`  in  ADDR_W  CPU word address.
- `avs_read`, `avs_write`  in  1  CPU requests.
- `avs_writedata`  in  32  CPU write data.
- `avs_byteenable`  in  4  CPU byte enables.
- `avs_waitrequest`  out  1  combinational stall.
- `avs_readdata`  out  32  CPU read data.
- `avs_readdatavalid`  out  1  one-cycle strobe.
- `MonDReg`  out  32  last JTAG read data.
- `MonAReg`  out  ADDR_W  current JTAG word address.
- `monitor_ready`  out  1  last accepted JTAG command has completed.
- `monitor_error`  out  1  sticky overrun flag.

## Operation
- FSM states: IDLE, RD_ISSUE, RD_CAPT, WR. Commands are accepted only in IDLE.
- Priority among same-cycle takes: `take_action_ocimem_a` > `take_action_ocimem_b` > `take_no_action_ocimem_a`. Lower-priority takes are dropped silently.
- Address load (`take_action_ocimem_a`):
  - `MonAReg <= jdo[ADDR_W-1:0]`.
  - If `jdo[34]`, `monitor_error <= 0`.
  - If `jdo[35]`, go to RD_ISSUE; otherwise stay IDLE and set `monitor_ready` next cycle.
- Read (`take_no_action_ocimem_a`, or a load with `jdo[35]` set):
  - RD_ISSUE drives the RAM with `MonAReg` and goes to RD_CAPT.
  - RD_CAPT loads `MonDReg <=` RAM q and returns to IDLE.
  - `take_no_action_ocimem_a` increments `MonAReg` at the end of RD_ISSUE. A load-with-read does not increment.
- Write (`take_action_ocimem_b`): WR writes all 4 bytes of the latched `jdo[31:0]` to `RAM[MonAReg]`, increments `MonAReg`, and returns to IDLE.
- `MonAReg` increments modulo 2^ADDR_W: all-ones -> 0.
- `monitor_ready`:
  - Cleared on the cycle after any accepted command.
  - Set on the cycle after completion (end of RD_CAPT, end of WR, or the load cycle for a load without read).
- Any `take_*` while not IDLE: the command is ignored, `monitor_error <= 1`, and FSM/registers are otherwise unchanged.
- CPU port:
  - `avs_waitrequest = (avs_read | avs_write) & (state == RD_ISSUE | state == WR)`.
  - An accepted read produces `avs_readdata` and `avs_readdatavalid` one cycle later.
  - An accepted write applies `avs_byteenable`.
  - A CPU write and a JTAG read of the same word are never in the same cycle (RAM is single-port); a CPU write accepted in IDLE is visible to a JTAG read issued later.

## Timing
- Reset values:
  - state IDLE, `MonAReg` 0, `MonDReg` 0.
  - `monitor_ready` 0, `monitor_error` 0.
  - `avs_readdata` 0, `avs_readdatavalid` 0.
  - RAM contents are not reset.
- Reset asserted in WR suppresses the RAM write. Reset in RD_* aborts the read: `MonDReg` goes to 0 and no increment occurs.
- Read latency: take at cycle T -> RD_ISSUE at T+1 -> RD_CAPT at T+2 -> `MonDReg` valid and `monitor_ready=1` at T+3. `MonAReg` (increment case) updates at T+2.
- Write latency: take at T -> WR at T+1 -> RAM updated, `MonAReg+1` and `monitor_ready=1` at T+2.
- Back-to-back: the next command is accepted no earlier than T+3 (read) or T+2 (write). Earlier takes set the error flag.
- CPU read: accepted at C -> data valid at C+1. Stalls last at most one cycle per JTAG RAM access.

## Test plan
- Reset, then load with `jdo[7:0]=0x10`, `jdo[35]=1`, with RAM[0x10]=0xDEADBEEF preloaded by CPU write -> `MonDReg=0xDEADBEEF`, `monitor_ready=1` at T+3, `MonAReg=0x10`.
- Load 0xFE, then write 0x11111111, 0x22222222, 0x33333333 via `take_action_ocimem_b` spaced 2 cycles apart -> RAM[0xFE]/[0xFF]/[0x00] hold these values, `MonAReg` goes 0xFF, 0x00, 0x01.
- Load 0x20, then 3× `take_no_action_ocimem_a` spaced 3 cycles apart over preloaded 0xA0, 0xA1, 0xA2 -> `MonDReg` sequence 0xA0, 0xA1, 0xA2, `MonAReg=0x23`.
- `take_action_ocimem_b` issued 1 cycle after a read take -> `monitor_error=1`, no RAM change, read completes normally. Then load with `jdo[34]=1` -> `monitor_error=0`.
- CPU `avs_read` held during a JTAG RD_ISSUE cycle -> `avs_waitrequest=1` for exactly that cycle, then `readdatavalid` with correct data. CPU write with `byteenable=4'b0010` of 0x0000AB00 over 0xFFFFFFFF -> 0xFFFFABFF.
- Reset asserted during WR -> target word unchanged, all outputs at reset values the next cycle.

Source files
------------

// File: rtl/nios2_jtag_ocimem_ctrl.sv
// JTAG debug-module OCI memory controller: services host reads/writes of a single-port
// debug RAM with address auto-increment, sharing the RAM with a CPU-side Avalon-MM slave.
module nios2_jtag_ocimem_ctrl #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [37:0]       jdo_i,
    input  logic              take_action_ocimem_a_i,
    input  logic              take_action_ocimem_b_i,
    input  logic              take_no_action_ocimem_a_i,
    input  logic [ADDR_W-1:0] avs_address_i,
    input  logic              avs_read_i,
    input  logic              avs_write_i,
    input  logic [31:0]       avs_writedata_i,
    input  logic [3:0]        avs_byteenable_i,
    output logic              avs_waitrequest_o,
    output logic [31:0]       avs_readdata_o,
    output logic              avs_readdatavalid_o,
    output logic [31:0]       mon_d_reg_o,
    output logic [ADDR_W-1:0] mon_a_reg_o,
    output logic              monitor_ready_o,
    output logic              monitor_error_o
);

    typedef enum logic [1:0] {StIdle, StRdIssue, StRdCapt, StWr} state_e;

    state_e            state_q;
    logic [31:0]       mem [0:(1 << ADDR_W) - 1];
    logic [ADDR_W-1:0] mon_a_reg_q;
    logic [31:0]       mon_d_reg_q;
    logic [31:0]       ram_q;
    logic [31:0]       wr_data_q;
    logic              inc_q;
    logic              ready_q;
    logic              error_q;
    logic [31:0]       avs_readdata_q;
    logic              avs_rdv_q;

    logic any_take;
    logic jtag_busy;
    logic cpu_rd;
    logic cpu_wr;
    logic unused_jdo;

    assign any_take  = take_action_ocimem_a_i | take_action_ocimem_b_i |
                       take_no_action_ocimem_a_i;
    // The JTAG side owns the RAM port in these two states.
    assign jtag_busy = (state_q == StRdIssue) || (state_q == StWr);
    assign cpu_rd    = avs_read_i & ~jtag_busy;
    assign cpu_wr    = avs_write_i & ~jtag_busy;
    assign unused_jdo = ^{jdo_i[37:36], jdo_i[33:32]};

    assign avs_waitrequest_o   = (avs_read_i | avs_write_i) & jtag_busy;
    assign avs_readdata_o      = avs_readdata_q;
    assign avs_readdatavalid_o = avs_rdv_q;
    assign mon_d_reg_o         = mon_d_reg_q;
    assign mon_a_reg_o         = mon_a_reg_q;
    assign monitor_ready_o     = ready_q;
    assign monitor_error_o     = error_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            mon_a_reg_q <= '0;
            mon_d_reg_q <= '0;
            ram_q       <= '0;
            wr_data_q   <= '0;
            inc_q       <= 1'b0;
            ready_q     <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (take_action_ocimem_a_i) begin
                        mon_a_reg_q <= jdo_i[ADDR_W-1:0];
                        if (jdo_i[34]) error_q <= 1'b0;
                        if (jdo_i[35]) begin
                            state_q <= StRdIssue;
                            inc_q   <= 1'b0;
                            ready_q <= 1'b0;
                        end else begin
                            ready_q <= 1'b1;
                        end
                    end else if (take_action_ocimem_b_i) begin
                        wr_data_q <= jdo_i[31:0];
                        state_q   <= StWr;
                        ready_q   <= 1'b0;
                    end else if (take_no_action_ocimem_a_i) begin
                        state_q <= StRdIssue;
                        inc_q   <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                StRdIssue: begin
                    ram_q   <= mem[mon_a_reg_q];
                    if (inc_q) mon_a_reg_q <= mon_a_reg_q + ADDR_W'(1);
                    if (any_take) error_q <= 1'b1;
                    state_q <= StRdCapt;
                end
                StRdCapt: begin
                    mon_d_reg_q <= ram_q;
                    ready_q     <= 1'b1;
                    if (any_take) error_q <= 1'b1;
                    state_q     <= StIdle;
                end
                StWr: begin
                    mon_a_reg_q <= mon_a_reg_q + ADDR_W'(1);
                    ready_q     <= 1'b1;
                    if (any_take) error_q <= 1'b1;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // RAM contents are not reset, but a reset cycle must not commit a write.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (state_q == StWr) begin
                mem[mon_a_reg_q] <= wr_data_q;
            end else if (cpu_wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (avs_byteenable_i[b]) mem[avs_address_i][8*b +: 8] <= avs_writedata_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            avs_readdata_q <= '0;
            avs_rdv_q      <= 1'b0;
        end else begin
            avs_rdv_q <= cpu_rd;
            if (cpu_rd) avs_readdata_q <= mem[avs_address_i];
        end
    end

endmodule

// File: tb/tb_nios2_jtag_ocimem_ctrl.sv
// Self-checking bench for nios2_jtag_ocimem_ctrl: directed scenarios plus a randomized
// command stream compared against a transaction-level memory/address model.
module tb_nios2_jtag_ocimem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        ta_a, ta_b, tn_a;
    logic [7:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic        avs_waitrequest;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic [31:0] mon_d;
    logic [7:0]  mon_a;
    logic        mon_ready, mon_error;

    int checks = 0;
    int passed = 0;

    // Reference model: what the host should observe once each command completes.
    logic [31:0] ref_mem [256];
    logic [7:0]  ref_a;
    logic [31:0] ref_d;
    logic        ref_err;

    always #5 clk = ~clk;

    nios2_jtag_ocimem_ctrl #(.ADDR_W(8)) dut (
        .clk_i                    (clk),
        .reset_i                  (reset),
        .jdo_i                    (jdo),
        .take_action_ocimem_a_i   (ta_a),
        .take_action_ocimem_b_i   (ta_b),
        .take_no_action_ocimem_a_i(tn_a),
        .avs_address_i            (avs_address),
        .avs_read_i               (avs_read),
        .avs_write_i              (avs_write),
        .avs_writedata_i          (avs_writedata),
        .avs_byteenable_i         (avs_byteenable),
        .avs_waitrequest_o        (avs_waitrequest),
        .avs_readdata_o           (avs_readdata),
        .avs_readdatavalid_o      (avs_readdatavalid),
        .mon_d_reg_o              (mon_d),
        .mon_a_reg_o              (mon_a),
        .monitor_ready_o          (mon_ready),
        .monitor_error_o          (mon_error)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
        step();
        avs_write = 1'b0;
        for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic cpu_read(input logic [7:0] a);
        avs_address = a; avs_read = 1'b1;
        step();
        avs_read = 1'b0;
    endtask

    task automatic pulse_load(input logic [7:0] a, input logic rd, input logic clr);
        jdo = {2'b00, rd, clr, 26'($urandom), a};
        ta_a = 1'b1;
        step();
        ta_a = 1'b0;
        ref_a = a;
        if (clr) ref_err = 1'b0;
        if (rd) ref_d = ref_mem[a];
    endtask

    task automatic pulse_write(input logic [31:0] d);
        jdo = {6'($urandom), d};
        ta_b = 1'b1;
        step();
        ta_b = 1'b0;
        ref_mem[ref_a] = d;
        ref_a = ref_a + 8'd1;
    endtask

    task automatic pulse_read();
        jdo = {6'($urandom), $urandom};
        tn_a = 1'b1;
        step();
        tn_a = 1'b0;
        ref_d = ref_mem[ref_a];
        ref_a = ref_a + 8'd1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        checks++; if (mon_a !== 8'h00) $display("FAIL reset mon_a: got %h want 00", mon_a); else passed++;
        checks++; if (mon_d !== 32'h0) $display("FAIL reset mon_d: got %h want 0", mon_d); else passed++;
        checks++; if (mon_ready !== 1'b0) $display("FAIL reset ready: got %b want 0", mon_ready); else passed++;
        checks++; if (mon_error !== 1'b0) $display("FAIL reset error: got %b want 0", mon_error); else passed++;
        checks++; if (avs_readdata !== 32'h0) $display("FAIL reset readdata: got %h want 0", avs_readdata); else passed++;
        checks++; if (avs_readdatavalid !== 1'b0) $display("FAIL reset rdv: got %b want 0", avs_readdatavalid); else passed++;
        reset = 1'b0;
        ref_a = 8'h00; ref_d = 32'h0; ref_err = 1'b0;
        step();
        for (int i = 0; i < 256; i++) cpu_write(8'(i), $urandom, 4'hF);
    endtask

    task automatic test_load_read();
        cpu_write(8'h10, 32'hDEADBEEF, 4'hF);
        pulse_load(8'h10, 1'b1, 1'b0);
        checks++; if (mon_ready !== 1'b0) $display("FAIL load_read ready T+1: got %b want 0", mon_ready); else passed++;
        step(); step();
        checks++; if (mon_d !== 32'hDEADBEEF) $display("FAIL load_read mon_d: got %h want deadbeef", mon_d); else passed++;
        checks++; if (mon_ready !== 1'b1) $display("FAIL load_read ready T+3: got %b want 1", mon_ready); else passed++;
        checks++; if (mon_a !== 8'h10) $display("FAIL load_read mon_a: got %h want 10", mon_a); else passed++;
    endtask

    task automatic test_write_wrap();
        logic [31:0] vals [3];
        logic [7:0]  want_a [3];
        vals = '{32'h11111111, 32'h22222222, 32'h33333333};
        want_a = '{8'hFF, 8'h00, 8'h01};
        pulse_load(8'hFE, 1'b0, 1'b0);
        checks++; if (mon_ready !== 1'b1) $display("FAIL wrap load ready: got %b want 1", mon_ready); else passed++;
        checks++; if (mon_a !== 8'hFE) $display("FAIL wrap load mon_a: got %h want fe", mon_a); else passed++;
        for (int i = 0; i < 3; i++) begin
            pulse_write(vals[i]);
            checks++; if (mon_ready !== 1'b0) $display("FAIL wrap ready T+1: got %b want 0", mon_ready); else passed++;
            step();
            checks++; if (mon_a !== want_a[i]) $display("FAIL wrap mon_a %0d: got %h want %h", i, mon_a, want_a[i]); else passed++;
            checks++; if (mon_ready !== 1'b1) $display("FAIL wrap ready T+2: got %b want 1", mon_ready); else passed++;
        end
        for (int i = 0; i < 3; i++) begin
            cpu_read(8'(8'hFE + i));
            checks++; if (avs_readdata !== vals[i]) $display("FAIL wrap ram %0d: got %h want %h", i, avs_readdata, vals[i]); else passed++;
        end
    endtask

    task automatic test_seq_read();
        for (int i = 0; i < 3; i++) cpu_write(8'(8'h20 + i), 32'(8'hA0 + i), 4'hF);
        pulse_load(8'h20, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            pulse_read();
            step();
            checks++; if (mon_a !== ref_a) $display("FAIL seq mon_a T+2 %0d: got %h want %h", i, mon_a, ref_a); else passed++;
            step();
            checks++; if (mon_d !== 32'(8'hA0 + i)) $display("FAIL seq mon_d %0d: got %h want %h", i, mon_d, 8'hA0 + i); else passed++;
            checks++; if (mon_ready !== 1'b1) $display("FAIL seq ready %0d: got %b want 1", i, mon_ready); else passed++;
        end
        checks++; if (mon_a !== 8'h23) $display("FAIL seq final mon_a: got %h want 23", mon_a); else passed++;
    endtask

    task automatic test_error();
        logic [7:0]  tgt;
        logic [31:0] old;
        pulse_load(8'h70, 1'b0, 1'b0);
        tgt = 8'h71;
        old = ref_mem[tgt];
        pulse_read();
        jdo = {6'h0, ~old};
        ta_b = 1'b1;
        step();
        ta_b = 1'b0;
        ref_err = 1'b1;
        checks++; if (mon_error !== 1'b1) $display("FAIL err flag: got %b want 1", mon_error); else passed++;
        step();
        checks++; if (mon_d !== ref_d) $display("FAIL err read data: got %h want %h", mon_d, ref_d); else passed++;
        checks++; if (mon_ready !== 1'b1) $display("FAIL err ready: got %b want 1", mon_ready); else passed++;
        checks++; if (mon_a !== ref_a) $display("FAIL err mon_a: got %h want %h", mon_a, ref_a); else passed++;
        cpu_read(tgt);
        checks++; if (avs_readdata !== old) $display("FAIL err ram untouched: got %h want %h", avs_readdata, old); else passed++;
        pulse_load(8'h05, 1'b0, 1'b1);
        checks++; if (mon_error !== 1'b0) $display("FAIL err clear: got %b want 0", mon_error); else passed++;
    endtask

    task automatic test_cpu_port();
        pulse_load(8'h30, 1'b0, 1'b0);
        pulse_read();
        avs_address = 8'h55; avs_read = 1'b1;
        #1;
        checks++; if (avs_waitrequest !== 1'b1) $display("FAIL stall in RD_ISSUE: got %b want 1", avs_waitrequest); else passed++;
        step();
        checks++; if (avs_waitrequest !== 1'b0) $display("FAIL stall released: got %b want 0", avs_waitrequest); else passed++;
        checks++; if (avs_readdatavalid !== 1'b0) $display("FAIL stall rdv early: got %b want 0", avs_readdatavalid); else passed++;
        step();
        avs_read = 1'b0;
        checks++; if (avs_readdatavalid !== 1'b1) $display("FAIL stall rdv: got %b want 1", avs_readdatavalid); else passed++;
        checks++; if (avs_readdata !== ref_mem[8'h55]) $display("FAIL stall data: got %h want %h", avs_readdata, ref_mem[8'h55]); else passed++;
        checks++; if (mon_d !== ref_d) $display("FAIL stall jtag data: got %h want %h", mon_d, ref_d); else passed++;
        cpu_write(8'h60, 32'hFFFFFFFF, 4'hF);
        cpu_write(8'h60, 32'h0000AB00, 4'b0010);
        cpu_read(8'h60);
        checks++; if (avs_readdata !== 32'hFFFFABFF) $display("FAIL byteenable: got %h want ffffabff", avs_readdata); else passed++;
    endtask

    task automatic test_reset_in_wr();
        logic [31:0] old;
        pulse_load(8'h40, 1'b0, 1'b0);
        old = ref_mem[8'h40];
        jdo = {6'h0, ~old};
        ta_b = 1'b1;
        step();
        ta_b = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        ref_a = 8'h00; ref_d = 32'h0; ref_err = 1'b0;
        checks++; if (mon_a !== 8'h00) $display("FAIL rst_wr mon_a: got %h want 00", mon_a); else passed++;
        checks++; if (mon_d !== 32'h0) $display("FAIL rst_wr mon_d: got %h want 0", mon_d); else passed++;
        checks++; if (mon_ready !== 1'b0) $display("FAIL rst_wr ready: got %b want 0", mon_ready); else passed++;
        checks++; if (avs_readdata !== 32'h0) $display("FAIL rst_wr readdata: got %h want 0", avs_readdata); else passed++;
        cpu_read(8'h40);
        checks++; if (avs_readdata !== old) $display("FAIL rst_wr ram: got %h want %h", avs_readdata, old); else passed++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            int unsigned op;
            logic inject;
            op = $urandom_range(0, 4);
            inject = ($urandom_range(0, 3) == 0);
            case (op)
                0: begin
                    logic rd;
                    rd = 1'($urandom);
                    pulse_load(8'($urandom), rd, 1'($urandom));
                    if (rd) begin
                        if (inject) begin
                            tn_a = 1'b1; step(); tn_a = 1'b0; ref_err = 1'b1;
                        end else begin
                            step();
                        end
                        step();
                    end
                end
                1: begin
                    pulse_write($urandom);
                    if (inject) begin
                        jdo = {2'b00, 2'b11, 34'($urandom)};
                        ta_a = 1'b1; step(); ta_a = 1'b0; ref_err = 1'b1;
                    end else begin
                        step();
                    end
                end
                2: begin
                    pulse_read();
                    if (inject) begin
                        ta_b = 1'b1; step(); ta_b = 1'b0; ref_err = 1'b1;
                    end else begin
                        step();
                    end
                    step();
                end
                3: cpu_write(8'($urandom), $urandom, 4'($urandom));
                default: begin
                    logic [7:0] a;
                    a = 8'($urandom);
                    cpu_read(a);
                    checks++; if (avs_readdatavalid !== 1'b1 || avs_readdata !== ref_mem[a])
                        $display("FAIL rand cpu_read %0d: got %b/%h want 1/%h", n, avs_readdatavalid, avs_readdata, ref_mem[a]);
                    else passed++;
                end
            endcase
            if (op <= 2) begin
                checks++; if (mon_a !== ref_a || mon_d !== ref_d || mon_ready !== 1'b1 || mon_error !== ref_err)
                    $display("FAIL rand jtag %0d op%0d: got a=%h d=%h rdy=%b err=%b want a=%h d=%h rdy=1 err=%b",
                             n, op, mon_a, mon_d, mon_ready, mon_error, ref_a, ref_d, ref_err);
                else passed++;
            end
        end
    endtask

    initial begin
        reset = 1'b1; jdo = '0; ta_a = 1'b0; ta_b = 1'b0; tn_a = 1'b0;
        avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
        avs_writedata = '0; avs_byteenable = '0;
        test_reset();
        test_load_read();
        test_write_wrap();
        test_seq_read();
        test_error();
        test_cpu_port();
        test_reset_in_wr();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
